clk_tick_stepper: RTL and testbench

//  Consumes the divided clock from the clock divider, resynchronises it into inclk, and turns each

---
 rtl/clk_tick_stepper_pkg.sv | 7 +
 rtl/clk_tick_stepper_sync_edge_det.sv | 30 +++
 rtl/clk_tick_stepper.sv | 80 ++++++++
 tb/tb_clk_tick_stepper.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_tick_stepper_pkg.sv
// clk_step_pkg: handshake FSM state type and default sizing shared by clk_tick_stepper and its synchroniser
package clk_step_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_REL} step_state_t;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W = 24;
  localparam int DEF_MISS_W = 8;
endpackage

// File: rtl/clk_tick_stepper_sync_edge_det.sv
// sync_edge_det: multi-flop synchroniser for an async level plus a one-cycle rising-edge pulse
// ports: inclk clock, rst async active-low reset, d async input, q_sync synchronised level, rise edge pulse
module sync_edge_det
  import clk_step_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic inclk,
  input  logic rst,
  input  logic d,
  output logic q_sync,
  output logic rise
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d;
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end
  always_ff @(posedge inclk or negedge rst)
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  assign q_sync = sync_q[STAGES-1];
  assign rise = q_sync & ~prev_q;
endmodule

// File: rtl/clk_tick_stepper.sv
// clk_tick_stepper: turns slowclk edges or step-button presses into 4-phase req/ack steps and counts steps/drops
// ports: inclk clock, rst async active-low reset, slowclk/step_btn async inputs, run_en free-run select,
//        clr_cnt sync counter clear, ack core acknowledge; req step request, busy FSM active, tick slowclk edge,
//        step_count wrapping step counter, miss_count saturating drop counter, missed sticky drop flag
module clk_tick_stepper
  import clk_step_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W = DEF_CNT_W,
  parameter int MISS_W = DEF_MISS_W
) (
  input  logic              inclk,
  input  logic              rst,
  input  logic              slowclk,
  input  logic              run_en,
  input  logic              step_btn,
  input  logic              clr_cnt,
  input  logic              ack,
  output logic              req,
  output logic              busy,
  output logic              tick,
  output logic [CNT_W-1:0]  step_count,
  output logic [MISS_W-1:0] miss_count,
  output logic              missed
);
  logic tick_w, btn_rise, sl_sync, btn_sync, unused_sync;
  logic launch, done, drop;
  step_state_t state_q, state_d;
  logic req_q, req_d, busy_q, busy_d, missed_q, missed_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic [MISS_W-1:0] miss_q, miss_d;

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sl (
    .inclk(inclk), .rst(rst), .d(slowclk), .q_sync(sl_sync), .rise(tick_w)
  );
  sync_edge_det #(.STAGES(SYNC_STAGES)) u_btn (
    .inclk(inclk), .rst(rst), .d(step_btn), .q_sync(btn_sync), .rise(btn_rise)
  );
  assign unused_sync = sl_sync & btn_sync;

  // the source not selected by run_en is simply ignored, so it never counts as a drop
  assign launch = run_en ? tick_w : btn_rise;
  assign done = (state_q == ST_REQ) && ack;
  assign drop = launch && (state_q != ST_IDLE);

  always_comb begin
    state_d = (state_q == ST_IDLE) ? (launch ? ST_REQ : ST_IDLE) :
              (state_q == ST_REQ)  ? (ack ? ST_REL : ST_REQ) :
                                     (ack ? ST_REL : ST_IDLE);
    req_d = (state_d == ST_REQ);
    busy_d = (state_d != ST_IDLE);
    step_d = clr_cnt ? '0 : step_q + CNT_W'(done);
    miss_d = clr_cnt ? '0 : miss_q + MISS_W'(drop && !(&miss_q));
    missed_d = !clr_cnt && (missed_q || drop);
  end

  always_ff @(posedge inclk or negedge rst)
    if (!rst) begin
      state_q <= ST_IDLE;
      req_q <= 1'b0;
      busy_q <= 1'b0;
      step_q <= '0;
      miss_q <= '0;
      missed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q <= req_d;
      busy_q <= busy_d;
      step_q <= step_d;
      miss_q <= miss_d;
      missed_q <= missed_d;
    end

  assign req = req_q;
  assign busy = busy_q;
  assign tick = tick_w;
  assign step_count = step_q;
  assign miss_count = miss_q;
  assign missed = missed_q;
endmodule

// File: tb/tb_clk_tick_stepper.sv
// tb_clk_tick_stepper: randomized scoreboard bench for clk_tick_stepper with a timestamp-level reference model
module tb_clk_tick_stepper;
  localparam int S = 2;
  logic inclk = 1'b0, rst = 1'b0, slowclk = 1'b0, run_en = 1'b0, step_btn = 1'b0, clr_cnt = 1'b0, ack = 1'b0;
  logic req, busy, tick, missed;
  logic [23:0] step_count;
  logic [7:0] miss_count;
  logic req_b, busy_b, tick_b, missed_b;
  logic [3:0] step_b;
  logic [1:0] miss_b;

  clk_tick_stepper dut (
    .inclk(inclk), .rst(rst), .slowclk(slowclk), .run_en(run_en), .step_btn(step_btn),
    .clr_cnt(clr_cnt), .ack(ack), .req(req), .busy(busy), .tick(tick),
    .step_count(step_count), .miss_count(miss_count), .missed(missed)
  );
  clk_tick_stepper #(.CNT_W(4), .MISS_W(2)) dut_b (
    .inclk(inclk), .rst(rst), .slowclk(slowclk), .run_en(run_en), .step_btn(step_btn),
    .clr_cnt(clr_cnt), .ack(ack), .req(req_b), .busy(busy_b), .tick(tick_b),
    .step_count(step_b), .miss_count(miss_b), .missed(missed_b)
  );

  always #5 inclk = ~inclk;

  typedef struct {int rise_cyc; int fall_cyc; longint steps;} exp_t;
  exp_t sb[$];
  bit sl_q[$], bt_q[$];
  int n_cmp = 0, n_bad = 0;
  int cyc, last_e, busy_until, ack_a, ack_dmin, ack_dmax;
  longint steps, misses;
  bit missed_m, chk_on, ack_force, clr_pulse, clr_on_done, clr_fired;
  int clr_fired_cyc, sl_half, sl_cnt, sl_rises_left, req_rises, ticks_seen, fall_exp;
  bit req_prev;

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    cyc = 0; steps = 0; misses = 0; missed_m = 0;
    last_e = 0; busy_until = -1; ack_a = -1000;
    sb.delete(); sl_q.delete(); bt_q.delete();
    for (int i = 0; i < S + 2; i++) begin
      sl_q.push_back(1'b0);
      bt_q.push_back(1'b0);
    end
    req_rises = 0; ticks_seen = 0; clr_on_done = 0; clr_fired = 0; clr_pulse = 0;
  endtask

  // one inclk cycle: consume the inputs sampled at this edge, then drive inputs for the next edge
  task automatic step_cycle();
    bit sl_e, bt_e, launch;
    @(posedge inclk);
    cyc++;
    sl_q.push_front(slowclk); void'(sl_q.pop_back());
    bt_q.push_front(step_btn); void'(bt_q.pop_back());
    sl_e = sl_q[S] && !sl_q[S+1];
    bt_e = bt_q[S] && !bt_q[S+1];
    launch = run_en ? sl_e : bt_e;
    if (clr_cnt) begin
      steps = 0; misses = 0; missed_m = 0;
    end else begin
      if (cyc == ack_a) steps++;
      if (launch && cyc <= busy_until) begin
        misses++; missed_m = 1;
      end
    end
    if (launch && cyc > busy_until) begin
      last_e = cyc;
      ack_a = cyc + 1 + int'($urandom_range(ack_dmax, ack_dmin));
      busy_until = ack_a + int'($urandom_range(3, 1));
      sb.push_back('{cyc, ack_a, steps});
    end
    #1;
    ack = ack_force || (cyc + 1 >= ack_a && cyc + 1 < busy_until);
    clr_cnt = clr_pulse;
    clr_pulse = 0;
    if (clr_on_done && cyc + 1 == ack_a) begin
      clr_cnt = 1; clr_on_done = 0; clr_fired = 1; clr_fired_cyc = cyc + 1;
    end
    if (sl_half > 0 && (slowclk || sl_rises_left > 0)) begin
      sl_cnt++;
      if (sl_cnt >= sl_half) begin
        sl_cnt = 0;
        slowclk = !slowclk;
        if (slowclk) sl_rises_left--;
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) step_cycle();
  endtask

  task automatic pulse_clr();
    clr_pulse = 1;
    run(2);
  endtask

  task automatic do_reset();
    chk_on = 0;
    rst = 0;
    #1;
    check("rst_req", req, 0);
    check("rst_busy", busy, 0);
    check("rst_tick", tick, 0);
    check("rst_step", step_count, 0);
    check("rst_miss", miss_count, 0);
    check("rst_missed", missed, 0);
    check("rst_step_b", step_b, 0);
    ack = ack_force;
    sl_rises_left = 0;
    repeat (3) @(posedge inclk);
    model_reset();
    @(negedge inclk);
    rst = 1;
    chk_on = 1;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_step"}, step_count, steps % (64'd1 << 24));
    check({tag, "_miss"}, miss_count, misses > 255 ? 255 : misses);
    check({tag, "_missed"}, missed, missed_m);
    check({tag, "_step_b"}, step_b, steps % 16);
    check({tag, "_miss_b"}, miss_b, misses > 3 ? 3 : misses);
    check({tag, "_missed_b"}, missed_b, missed_m);
    check({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic settle(input string tag);
    sl_rises_left = 0;
    step_btn = 0;
    run(40);
    check_counts(tag);
  endtask

  always @(negedge inclk) begin
    if (!rst || !chk_on) req_prev = 0;
    else begin
      check("tick", tick, sl_q[S-1] && !sl_q[S]);
      check("tick_b", tick_b, sl_q[S-1] && !sl_q[S]);
      check("busy", busy, cyc >= last_e && cyc < busy_until);
      check("busy_b", busy_b, cyc >= last_e && cyc < busy_until);
      check("req_b", req_b, req);
      if (tick) ticks_seen++;
      if (req && !req_prev) begin
        req_rises++;
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL req_unexpected: req rose at cycle %0d, no request expected", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("req_rise_cyc", cyc, e.rise_cyc);
          check("step_at_req", step_count, e.steps % (64'd1 << 24));
          fall_exp = e.fall_cyc;
        end
      end
      if (!req && req_prev) check("req_fall_cyc", cyc, fall_exp);
      req_prev = req;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ack_dmin = 0; ack_dmax = 0; sl_half = 0; sl_cnt = 0;
    model_reset();
    // reset with slowclk and ack high, single-step mode
    slowclk = 1; ack_force = 1; run_en = 0;
    do_reset();
    run(3);
    ack_force = 0;
    run(10);
    check("t1_ticks", ticks_seen, 1);
    check("t1_no_req", req_rises, 0);
    check_counts("t1");
    // free-run, ack two cycles after req
    run_en = 1; ack_dmin = 1; ack_dmax = 1;
    sl_half = 8; sl_cnt = 0; sl_rises_left = 5;
    run(110);
    settle("t2");
    check("t2_step5", step_count, 5);
    check("t2_miss0", miss_count, 0);
    // ack held off, launches dropped
    pulse_clr();
    ack_dmin = 20; ack_dmax = 20;
    sl_half = 4; sl_rises_left = 3;
    run(60);
    settle("t3");
    check("t3_step1", step_count, 1);
    check("t3_miss2", miss_count, 2);
    check("t3_missed", missed, 1);
    // single-step with slowclk running in the background
    run_en = 0; ack_dmin = 0; ack_dmax = 4;
    pulse_clr();
    sl_half = 3; sl_rises_left = 12;
    for (int p = 0; p < 3; p++) begin
      step_btn = 1; run(3);
      step_btn = 0; run(12);
    end
    run(20);
    settle("t4");
    check("t4_step3", step_count, 3);
    check("t4_miss0", miss_count, 0);
    // heavy traffic for wrap and saturation on the narrow instance
    pulse_clr();
    run_en = 1; ack_dmin = 0; ack_dmax = 5;
    sl_half = 2; sl_rises_left = 80;
    run(360);
    settle("t5");
    // clear landing on the same edge as a completing ack
    sl_half = 2; sl_rises_left = 5; clr_on_done = 1;
    for (int k = 0; k < 100 && !(clr_fired && cyc >= clr_fired_cyc); k++) step_cycle();
    check("t5_clr_fired", clr_fired, 1);
    if (clr_fired) begin
      @(negedge inclk);
      #1;
      check("t5_clr_step", step_count, 0);
      check("t5_clr_step_b", step_b, 0);
      check("t5_clr_miss_b", miss_b, 0);
      check("t5_clr_missed", missed, 0);
    end
    settle("t5b");
    // reset in the middle of a request
    pulse_clr();
    ack_dmin = 2; ack_dmax = 4;
    sl_half = 3; sl_rises_left = 20;
    for (int k = 0; k < 300 && !(steps >= 2 && cyc >= last_e && cyc < ack_a); k++) step_cycle();
    check("t6_in_req", req, 1);
    @(negedge inclk);
    #2;
    do_reset();
    sl_rises_left = 6;
    run(80);
    check("t6_fresh_req", req_rises > 0, 1);
    settle("t6");
    // random mix of mode changes, button activity and clears
    ack_dmin = 0; ack_dmax = 6;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(40, 0) == 0) run_en = !run_en;
      if ($urandom_range(5, 0) == 0) step_btn = !step_btn;
      if ($urandom_range(90, 0) == 0) clr_pulse = 1;
      if (sl_rises_left == 0) begin
        sl_half = int'($urandom_range(6, 2));
        sl_rises_left = int'($urandom_range(6, 1));
      end
      step_cycle();
    end
    settle("t7");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
